// File: rtl/bitty_fetch_sequencer_if.sv
// Instruction-memory and core-side signals between the fetch sequencer and its neighbours.
interface bitty_fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_data;
    logic              mem_valid;
    logic [15:0]       instr;
    logic              run;
    logic              done;

    // Sequencer side: drives the memory read and the core issue.
    modport master (
        output mem_addr,
        output mem_rd,
        output instr,
        output run,
        input  mem_data,
        input  mem_valid,
        input  done
    );

    // Memory/core side.
    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  instr,
        input  run,
        output mem_data,
        output mem_valid,
        output done
    );
endinterface

// File: rtl/bitty_fetch_sequencer.sv
// Fetch/issue sequencer for the bitty core: walks pc over instruction memory,
// issues each word with a one-cycle run pulse and waits for done, with a
// per-step watchdog, halt at instruction boundaries and an executed counter.
module bitty_fetch_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     halt,
    input  logic [ADDR_W:0]          prog_len,
    bitty_fetch_sequencer_if.master  bus,
    output logic                     busy,
    output logic                     finished,
    output logic                     timeout_err,
    output logic [ADDR_W-1:0]        pc,
    output logic [15:0]              instr_count
);
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_MEM = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_EXEC     = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [2:0] S_ERR      = 3'd7;

    logic [2:0]         state;
    logic [2:0]         state_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [WD_W-1:0]    wd_q;
    logic [WD_W-1:0]    wd_d;
    logic [INSTR_W-1:0] instr_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [LEN_W-1:0]   pc_inc_c;
    logic               wd_last_c;

    // Next-state and next-value logic for every register in the block.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        len_d     = len_q;
        wd_d      = wd_q;
        instr_d   = bus.instr;
        cnt_d     = instr_count;
        pc_inc_c  = LEN_W'(pc) + LEN_W'(1);
        wd_last_c = (wd_q == WD_W'(TIMEOUT - 1));

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                    state_d = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                wd_d    = '0;
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (bus.mem_valid) begin
                    instr_d = bus.mem_data;
                    state_d = S_ISSUE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_last_c) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (bus.done) begin
                    state_d = S_NEXT;
                    if (instr_count != '1) begin
                        cnt_d = instr_count + CNT_W'(1);
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_last_c) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_NEXT: begin
                // Completion wins over halt; pc stays on the last address.
                if (pc_inc_c == len_q) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc + ADDR_W'(1);
                    state_d = halt ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; strobes and flags decode the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            len_q        <= '0;
            wd_q         <= '0;
            instr_count  <= '0;
            bus.instr    <= '0;
            bus.mem_addr <= '0;
            bus.mem_rd   <= 1'b0;
            bus.run      <= 1'b0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            len_q        <= len_d;
            wd_q         <= wd_d;
            instr_count  <= cnt_d;
            bus.instr    <= instr_d;
            bus.mem_addr <= pc_d;
            bus.mem_rd   <= (state_d == S_FETCH);
            bus.run      <= (state_d == S_ISSUE);
            busy         <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
            finished     <= (state_d == S_DONE);
            timeout_err  <= (state_d == S_ERR);
        end
    end
endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// Scoreboard bench for bitty_fetch_sequencer: randomized memory/core responders,
// a program-level reference model filling expectation queues, and a monitor
// that checks every run pulse, every fetch and every end-of-program state.
module tb_bitty_fetch_sequencer;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned NUM_RUNS = 40;
    localparam int unsigned MEM_SZ   = 1 << ADDR_W;
    localparam int          BOUND    = 5000;

    typedef struct {
        int status;   // 0 idle (halted), 1 finished, 2 timeout
        int pc;
        int count;
        int runs;
        int reads;
    } end_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              busy;
    logic              finished;
    logic              timeout_err;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr_count;

    bitty_fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    bitty_fetch_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .prog_len    (prog_len),
        .bus         (bus.master),
        .busy        (busy),
        .finished    (finished),
        .timeout_err (timeout_err),
        .pc          (pc),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [15:0] mem [0:MEM_SZ-1];
    logic [15:0] exp_instr_q[$];
    end_t        exp_end_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ends_seen = 0;
    int run_gen = 0;
    int hang_mem_idx = -1;
    int hang_core_idx = -1;
    int halt_idx = -1;
    bit fixed_lat = 1'b0;
    bit models_en = 1'b0;
    int last_valid_cycle = 0;
    int last_done_cycle = 0;
    int last_run_cycle = 0;
    int last_rd_cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Memory and core responders: random latencies, stray mem_valid/done/halt.
    initial begin : models
        bit mem_pend;
        bit core_pend;
        bit next_flag;
        bit done_hold;
        int mem_cnt;
        int core_cnt;
        int comp_idx;
        int rd_idx;
        int run_idx;
        int seen_gen;
        logic [ADDR_W-1:0] mem_a;
        mem_pend = 0; core_pend = 0; next_flag = 0; done_hold = 0;
        mem_cnt = 0; core_cnt = 0; comp_idx = -1; rd_idx = 0; run_idx = 0; seen_gen = 0;
        mem_a = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!models_en || !rst) begin
                mem_pend = 0; core_pend = 0; next_flag = 0; done_hold = 0;
                if (models_en) begin
                    bus.mem_valid = 1'b0;
                    bus.done = 1'b0;
                    halt = 1'b0;
                end
                continue;
            end
            if (seen_gen != run_gen) begin
                seen_gen = run_gen;
                rd_idx = 0;
                run_idx = 0;
                comp_idx = -1;
            end
            // core side
            bus.done = done_hold;
            done_hold = 0;
            halt = !fixed_lat && ($urandom_range(0, 4) == 0);
            if (next_flag) begin
                halt = (comp_idx == halt_idx);
                next_flag = 0;
            end
            if (core_pend) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.done = 1'b1;
                    core_pend = 0;
                    comp_idx = run_idx - 1;
                    next_flag = 1;
                    last_done_cycle = cycle;
                    halt = (comp_idx == halt_idx);
                    done_hold = !fixed_lat && ($urandom_range(0, 1) == 1);
                end
            end
            if (bus.run) begin
                if (run_idx != hang_core_idx) begin
                    core_pend = 1;
                    core_cnt = fixed_lat ? 3 : int'($urandom_range(1, 4));
                end
                run_idx++;
            end
            if (!fixed_lat && mem_pend && ($urandom_range(0, 2) == 0)) bus.done = 1'b1;
            // memory side
            bus.mem_valid = 1'b0;
            bus.mem_data = 16'($urandom);
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_data = mem[mem_a];
                    mem_pend = 0;
                    last_valid_cycle = cycle;
                end
            end
            if (bus.mem_rd) begin
                if (rd_idx != hang_mem_idx) begin
                    mem_pend = 1;
                    mem_a = bus.mem_addr;
                    mem_cnt = fixed_lat ? 1 : int'($urandom_range(1, 3));
                end
                rd_idx++;
            end
            if (!fixed_lat && core_pend && ($urandom_range(0, 2) == 0)) bus.mem_valid = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT issues, fetches or ends a program.
    initial begin : monitor
        bit   pend_end;
        bit   prev_run;
        bit   prev_err;
        int   acc_cycle;
        int   runs_seen;
        int   reads_seen;
        int   ref_cycle;
        end_t e;
        pend_end = 0; prev_run = 0; prev_err = 0;
        acc_cycle = 0; runs_seen = 0; reads_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend_end = 0; prev_run = 0; prev_err = 0;
                continue;
            end
            if (bus.run) begin
                check("run_expected", 32'(exp_instr_q.size() > 0), 1);
                if (exp_instr_q.size() > 0) check("instr", bus.instr, exp_instr_q.pop_front());
                check("run_pulse_width", prev_run, 0);
                check("run_after_valid", cycle - last_valid_cycle, 1);
                runs_seen++;
                last_run_cycle = cycle;
            end
            if (bus.mem_rd) begin
                if (reads_seen == 0) check("first_rd_latency", cycle - acc_cycle, 1);
                else check("rd_after_done", cycle - last_done_cycle, 2);
                check("rd_addr", bus.mem_addr, reads_seen);
                check("pc_eq_addr", pc, reads_seen);
                reads_seen++;
                last_rd_cycle = cycle;
            end
            if (timeout_err && !prev_err) begin
                ref_cycle = (last_run_cycle > last_rd_cycle) ? last_run_cycle : last_rd_cycle;
                check("watchdog_latency", cycle - ref_cycle, TIMEOUT + 1);
            end
            if (pend_end && !busy) begin
                check("end_expected", 32'(exp_end_q.size() > 0), 1);
                if (exp_end_q.size() > 0) begin
                    e = exp_end_q.pop_front();
                    check("end_status", {timeout_err, finished}, (e.status == 1) ? 1 : (e.status == 2) ? 2 : 0);
                    check("end_pc", pc, e.pc);
                    check("end_count", instr_count, e.count);
                    check("end_runs", runs_seen, e.runs);
                    check("end_reads", reads_seen, e.reads);
                    check("instr_left", exp_instr_q.size(), 0);
                end
                pend_end = 0;
                ends_seen++;
            end
            if (start && !busy) begin
                pend_end = 1;
                acc_cycle = cycle;
                runs_seen = 0;
                reads_seen = 0;
            end
            prev_run = bus.run;
            prev_err = timeout_err;
        end
    end

    // Reference model of a whole program run, then start it and wait for its end.
    task automatic run_prog(input int len, input bit fixed, input int hm, input int hc, input int hi);
        end_t e;
        int   target;
        int   waited;
        fixed_lat = fixed;
        hang_mem_idx = hm;
        hang_core_idx = hc;
        halt_idx = hi;
        run_gen++;
        e.status = 1; e.pc = 0; e.count = 0; e.runs = 0; e.reads = 0;
        for (int i = 0; i < len; i++) begin
            e.reads = i + 1;
            if (i == hm) begin e.status = 2; e.pc = i; break; end
            exp_instr_q.push_back(mem[i]);
            e.runs = i + 1;
            if (i == hc) begin e.status = 2; e.pc = i; break; end
            e.count = i + 1;
            if (i + 1 == len) begin e.status = 1; e.pc = i; break; end
            if (i == hi) begin e.status = 0; e.pc = i + 1; break; end
        end
        exp_end_q.push_back(e);
        target = ends_seen + 1;
        start = 1'b1;
        prog_len = (ADDR_W + 1)'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        waited = 0;
        while (ends_seen < target && waited < BOUND) begin
            // start while busy must be ignored
            start = busy && !fixed && ($urandom_range(0, 7) == 0);
            if (start) prog_len = (ADDR_W + 1)'($urandom_range(0, 20));
            @(posedge clk);
            #1;
            waited++;
        end
        start = 1'b0;
        if (ends_seen < target) begin
            check("program_end_timeout", ends_seen, target);
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            exp_instr_q.delete();
            exp_end_q.delete();
            rst = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int len;
        int sc;
        bus.mem_valid = 1'b0;
        bus.done = 1'b0;
        bus.mem_data = '0;
        for (int i = 0; i < int'(MEM_SZ); i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_pc", pc, 0);
        check("rst_count", instr_count, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_run", bus.run, 0);
        rst = 1'b1;
        models_en = 1'b1;
        @(posedge clk);
        #1;

        mem[0] = 16'h0041; mem[1] = 16'h1283; mem[2] = 16'h2005;
        run_prog(3, 1, -1, -1, -1);
        run_prog(0, 1, -1, -1, -1);
        run_prog(4, 1, -1, 0, -1);
        run_prog(2, 1, -1, -1, -1);
        run_prog(5, 1, -1, -1, 1);
        run_prog(3, 1, 1, -1, -1);

        for (int r = 0; r < int'(NUM_RUNS); r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            len = $urandom_range(0, 12);
            sc = $urandom_range(0, 5);
            if (len == 0) run_prog(0, 0, -1, -1, -1);
            else if (sc == 0) run_prog(len, 0, $urandom_range(0, len - 1), -1, -1);
            else if (sc == 1) run_prog(len, 0, -1, $urandom_range(0, len - 1), -1);
            else if (sc == 2) run_prog(len, 0, -1, -1, $urandom_range(0, len - 1));
            else run_prog(len, 0, -1, -1, -1);
        end

        // full address space: pc reaches its maximum without wrapping
        for (int i = 0; i < int'(MEM_SZ); i++) mem[i] = 16'($urandom);
        run_prog(int'(MEM_SZ), 1, -1, -1, -1);

        // asynchronous reset while waiting on memory
        mem[0] = 16'h5A5A;
        run_prog(1, 1, -1, -1, -1);
        fixed_lat = 1'b1;
        hang_mem_idx = 0;
        hang_core_idx = -1;
        halt_idx = -1;
        run_gen++;
        start = 1'b1;
        prog_len = (ADDR_W + 1)'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_instr", bus.instr, 16'h5A5A);
        models_en = 1'b0;
        bus.mem_valid = 1'b0;
        bus.done = 1'b0;
        halt = 1'b0;
        rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_mem_rd", bus.mem_rd, 0);
        check("async_rst_run", bus.run, 0);
        check("async_rst_instr", bus.instr, 0);
        check("async_rst_pc", pc, 0);
        check("async_rst_flags", {timeout_err, finished}, 0);
        exp_instr_q.delete();
        exp_end_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b1;
        bus.mem_data = 16'hBEEF;
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("late_valid_instr", bus.instr, 0);
        check("late_valid_busy", busy, 0);
        check("late_valid_run", bus.run, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
